// File: rtl/gpio_port_pkg.sv
// Shared definitions for the GPIO port: register indices and bus FSM states.
package gpio_port_pkg;

    localparam logic [2:0] GPIO_OUT     = 3'd0;
    localparam logic [2:0] GPIO_DIR     = 3'd1;
    localparam logic [2:0] GPIO_IN      = 3'd2;
    localparam logic [2:0] GPIO_RISE_EN = 3'd3;
    localparam logic [2:0] GPIO_FALL_EN = 3'd4;
    localparam logic [2:0] GPIO_STATUS  = 3'd5;
    localparam logic [2:0] GPIO_SET     = 3'd6;
    localparam logic [2:0] GPIO_CLR     = 3'd7;

    typedef enum logic {
        IDLE = 1'b0,
        ACK  = 1'b1
    } state_t;

endpackage

// File: rtl/gpio_sync.sv
// Multi-flop synchroniser for asynchronous pad inputs; clears to 0 on reset.
module gpio_sync #(
    parameter int WIDTH  = 8,
    parameter int STAGES = 2
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [STAGES-1:0][WIDTH-1:0] chain;

    // Shift the pad value through the flop chain; the oldest entry is the output.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            chain <= '0;
        end else begin
            chain <= {chain[STAGES-2:0], d};
        end
    end

    assign q = chain[STAGES-1];

endmodule

// File: rtl/gpio_port.sv
// GPIO port: register file, bus handshake, input synchroniser, edge interrupts.
//
// state | meaning
// ------+------------------------------------------------------------
// IDLE  | waiting for a request; a request here is performed at once
// ACK   | o_ready high for this single cycle, then back to IDLE
module gpio_port #(
    parameter int               WIDTH       = 8,
    parameter int               SYNC_STAGES = 2,
    parameter logic [WIDTH-1:0] OUT_RESET   = '0,
    parameter logic [WIDTH-1:0] DIR_RESET   = '0
) (
    input  logic             i_clock,
    input  logic             i_reset,
    input  logic             i_request,
    input  logic             i_rw,
    input  logic [2:0]       i_address,
    input  logic [31:0]      i_wdata,
    output logic [31:0]      o_rdata,
    output logic             o_ready,
    output logic             o_interrupt,
    input  logic [WIDTH-1:0] i_gpio_in,
    output logic [WIDTH-1:0] o_gpio_out,
    output logic [WIDTH-1:0] o_gpio_oe
);
    import gpio_port_pkg::*;

    state_t           state;
    logic [WIDTH-1:0] out_reg;
    logic [WIDTH-1:0] dir_reg;
    logic [WIDTH-1:0] rise_en;
    logic [WIDTH-1:0] fall_en;
    logic [WIDTH-1:0] status;
    logic [WIDTH-1:0] in_sync;
    logic [WIDTH-1:0] in_prev;
    logic [WIDTH-1:0] wdata;
    logic [WIDTH-1:0] read_val;
    logic [WIDTH-1:0] rise;
    logic [WIDTH-1:0] fall;
    logic [WIDTH-1:0] w1c;
    logic             accept;
    logic             write;
    logic             wdata_unused;

    // Bits above WIDTH are deliberately dropped on writes.
    assign wdata        = i_wdata[WIDTH-1:0];
    assign wdata_unused = ^i_wdata;

    assign accept = (state == IDLE) && i_request;
    assign write  = accept && i_rw;

    gpio_sync #(
        .WIDTH  (WIDTH),
        .STAGES (SYNC_STAGES)
    ) u_sync (
        .clock (i_clock),
        .reset (i_reset),
        .d     (i_gpio_in),
        .q     (in_sync)
    );

    assign rise = in_sync & ~in_prev & rise_en;
    assign fall = ~in_sync & in_prev & fall_en;
    assign w1c  = (write && i_address == GPIO_STATUS) ? wdata : '0;

    // Read mux; write-only and out-of-range registers read as zero.
    always_comb begin
        read_val = '0;
        case (i_address)
            GPIO_OUT:     read_val = out_reg;
            GPIO_DIR:     read_val = dir_reg;
            GPIO_IN:      read_val = in_sync;
            GPIO_RISE_EN: read_val = rise_en;
            GPIO_FALL_EN: read_val = fall_en;
            GPIO_STATUS:  read_val = status;
            default:      read_val = '0;
        endcase
    end

    // Bus FSM: one cycle of ACK after every accepted request.
    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            state <= IDLE;
        end else begin
            case (state)
                IDLE:    if (i_request) state <= ACK;
                default: state <= IDLE;
            endcase
        end
    end

    assign o_ready = (state == ACK);

    // Read data is captured at acceptance and held only for the ACK cycle.
    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            o_rdata <= '0;
        end else begin
            o_rdata <= (accept && !i_rw) ? 32'(read_val) : '0;
        end
    end

    // Writable configuration registers, including SET/CLR side doors into OUT.
    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            out_reg <= OUT_RESET;
            dir_reg <= DIR_RESET;
            rise_en <= '0;
            fall_en <= '0;
        end else if (write) begin
            case (i_address)
                GPIO_OUT:     out_reg <= wdata;
                GPIO_DIR:     dir_reg <= wdata;
                GPIO_RISE_EN: rise_en <= wdata;
                GPIO_FALL_EN: fall_en <= wdata;
                GPIO_SET:     out_reg <= out_reg | wdata;
                GPIO_CLR:     out_reg <= out_reg & ~wdata;
                default:      ;
            endcase
        end
    end

    // Edge capture: a new edge beats a simultaneous write-1-to-clear.
    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            in_prev <= '0;
            status  <= '0;
        end else begin
            in_prev <= in_sync;
            status  <= (status & ~w1c) | rise | fall;
        end
    end

    // Registered level interrupt follows any pending status bit.
    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            o_interrupt <= 1'b0;
        end else begin
            o_interrupt <= |status;
        end
    end

    assign o_gpio_out = out_reg;
    assign o_gpio_oe  = dir_reg;

endmodule

// File: tb/tb_gpio_port.sv
// Directed bench for gpio_port: a vector table plus hand-timed corner sequences.
module tb_gpio_port;
    import gpio_port_pkg::*;

    localparam int SYNC = 2;

    typedef struct {
        logic        rw;
        logic [2:0]  addr;
        logic [31:0] wdata;
        int          hold;
        logic        chk;
        logic [31:0] exp;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_a, req_b, rw;
    logic [2:0]  addr;
    logic [31:0] wdata;
    logic [31:0] rdata_a, rdata_b;
    logic        ready_a, ready_b, irq_a, irq_b;
    logic [7:0]  pad_a, pad_drive, gout_a, goe_a;
    logic        loop_a;
    logic [3:0]  pad_b, gout_b, goe_b;

    int          vectors = 0;
    int          errors  = 0;
    int          n;
    int          pulses;
    logic [31:0] rd;
    vec_t        tbl [18];

    always #5 clk = ~clk;

    assign pad_a = loop_a ? gout_a : pad_drive;
    assign pad_b = 4'h0;

    gpio_port #(
        .WIDTH(8), .SYNC_STAGES(SYNC), .OUT_RESET(8'hA5), .DIR_RESET(8'h0F)
    ) dut_a (
        .i_clock(clk), .i_reset(rst), .i_request(req_a), .i_rw(rw),
        .i_address(addr), .i_wdata(wdata), .o_rdata(rdata_a), .o_ready(ready_a),
        .o_interrupt(irq_a), .i_gpio_in(pad_a), .o_gpio_out(gout_a), .o_gpio_oe(goe_a)
    );

    gpio_port #(
        .WIDTH(4), .SYNC_STAGES(SYNC), .OUT_RESET(4'h0), .DIR_RESET(4'h0)
    ) dut_b (
        .i_clock(clk), .i_reset(rst), .i_request(req_b), .i_rw(rw),
        .i_address(addr), .i_wdata(wdata), .o_rdata(rdata_b), .o_ready(ready_b),
        .o_interrupt(irq_b), .i_gpio_in(pad_b), .o_gpio_out(gout_b), .o_gpio_oe(goe_b)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Holds the request for 'hold' rising edges, then watches two more edges.
    task automatic bus(input bit sel_b, input logic w, input logic [2:0] a,
                       input logic [31:0] d, input int hold,
                       output logic [31:0] rdo, output int np);
        @(negedge clk);
        rw = w; addr = a; wdata = d;
        if (sel_b) req_b = 1'b1; else req_a = 1'b1;
        np  = 0;
        rdo = '0;
        for (int i = 0; i < hold + 2; i++) begin
            @(posedge clk); #1;
            if (sel_b ? ready_b : ready_a) begin
                np++;
                if (np == 1) rdo = sel_b ? rdata_b : rdata_a;
            end
            if (i == hold - 1) begin
                @(negedge clk);
                req_a = 1'b0; req_b = 1'b0;
            end
        end
    endtask

    initial begin
        tbl[0]  = '{1'b0, GPIO_OUT,     32'h0,         1, 1'b1, 32'h0000_00A5};
        tbl[1]  = '{1'b0, GPIO_DIR,     32'h0,         1, 1'b1, 32'h0000_000F};
        tbl[2]  = '{1'b0, GPIO_STATUS,  32'h0,         1, 1'b1, 32'h0};
        tbl[3]  = '{1'b0, GPIO_IN,      32'h0,         1, 1'b1, 32'h0};
        tbl[4]  = '{1'b1, GPIO_OUT,     32'h0,         2, 1'b0, 32'h0};
        tbl[5]  = '{1'b1, GPIO_SET,     32'h81,        2, 1'b0, 32'h0};
        tbl[6]  = '{1'b1, GPIO_CLR,     32'h01,        2, 1'b0, 32'h0};
        tbl[7]  = '{1'b0, GPIO_OUT,     32'h0,         1, 1'b1, 32'h0000_0080};
        tbl[8]  = '{1'b0, GPIO_SET,     32'h0,         1, 1'b1, 32'h0};
        tbl[9]  = '{1'b0, GPIO_CLR,     32'h0,         1, 1'b1, 32'h0};
        tbl[10] = '{1'b1, GPIO_RISE_EN, 32'h0000_01FF, 1, 1'b0, 32'h0};
        tbl[11] = '{1'b0, GPIO_RISE_EN, 32'h0,         1, 1'b1, 32'h0000_00FF};
        tbl[12] = '{1'b1, GPIO_FALL_EN, 32'hFFFF_FF03, 1, 1'b0, 32'h0};
        tbl[13] = '{1'b0, GPIO_FALL_EN, 32'h0,         1, 1'b1, 32'h0000_0003};
        tbl[14] = '{1'b1, GPIO_RISE_EN, 32'h0,         1, 1'b0, 32'h0};
        tbl[15] = '{1'b1, GPIO_FALL_EN, 32'h0,         1, 1'b0, 32'h0};
        tbl[16] = '{1'b1, GPIO_DIR,     32'h5A,        1, 1'b0, 32'h0};
        tbl[17] = '{1'b0, GPIO_DIR,     32'h0,         1, 1'b1, 32'h0000_005A};

        rst = 1'b1; req_a = 1'b0; req_b = 1'b0; rw = 1'b0; addr = '0; wdata = '0;
        pad_drive = 8'h00; loop_a = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk); rst = 1'b0;
        @(posedge clk); #1;

        check("reset_out", 32'(gout_a), 32'hA5);
        check("reset_oe", 32'(goe_a), 32'h0F);
        check("reset_irq", 32'(irq_a), 32'h0);
        check("reset_ready", 32'(ready_a), 32'h0);
        check("reset_rdata", rdata_a, 32'h0);

        for (int i = 0; i < 18; i++) begin
            bus(1'b0, tbl[i].rw, tbl[i].addr, tbl[i].wdata, tbl[i].hold, rd, pulses);
            check($sformatf("vec%0d_pulses", i), 32'(pulses), 32'd1);
            if (tbl[i].chk) check($sformatf("vec%0d_rdata", i), rd, tbl[i].exp);
        end
        check("pins_out", 32'(gout_a), 32'h80);
        check("pins_oe", 32'(goe_a), 32'h5A);

        // Request still high after ACK starts a second transaction.
        bus(1'b0, 1'b1, GPIO_OUT, 32'h11, 3, rd, pulses);
        check("held_req_pulses", 32'(pulses), 32'd2);

        // Loopback of the driven pins into IN.
        bus(1'b0, 1'b1, GPIO_DIR, 32'hFF, 1, rd, pulses);
        loop_a = 1'b1;
        bus(1'b0, 1'b1, GPIO_OUT, 32'h3C, 1, rd, pulses);
        bus(1'b0, 1'b0, GPIO_IN, 32'h0, 1, rd, pulses);
        check("loopback_in", rd, 32'h3C);
        check("loopback_irq", 32'(irq_a), 32'h0);

        @(negedge clk); loop_a = 1'b0; pad_drive = 8'h00;
        repeat (4) @(posedge clk);
        bus(1'b0, 1'b1, GPIO_RISE_EN, 32'h01, 1, rd, pulses);
        bus(1'b0, 1'b1, GPIO_STATUS, 32'hFF, 1, rd, pulses);
        bus(1'b0, 1'b0, GPIO_STATUS, 32'h0, 1, rd, pulses);
        check("pre_rise_status", rd, 32'h0);

        // Rise on pin 0 raises the interrupt after the synchroniser delay.
        @(negedge clk); pad_drive[0] = 1'b1;
        n = 0;
        do begin
            @(posedge clk); #1; n++;
        end while (!irq_a && n < 10);
        vectors++;
        if (!(irq_a && n >= SYNC + 1 && n <= SYNC + 3)) begin
            errors++;
            $display("FAIL rise_irq_latency: irq=%0b after %0d cycles, expected 1 within %0d..%0d",
                     irq_a, n, SYNC + 1, SYNC + 3);
        end
        bus(1'b0, 1'b0, GPIO_STATUS, 32'h0, 1, rd, pulses);
        check("rise_status", rd, 32'h01);

        // W1C: interrupt is still high at the clearing edge, low one cycle later.
        @(negedge clk); rw = 1'b1; addr = GPIO_STATUS; wdata = 32'h01; req_a = 1'b1;
        @(posedge clk); #1;
        check("irq_at_clear_edge", 32'(irq_a), 32'h1);
        @(negedge clk); req_a = 1'b0;
        @(posedge clk); #1;
        check("irq_after_clear", 32'(irq_a), 32'h0);

        // Fall on pin 1 lands in the same cycle as its W1C.
        @(negedge clk); pad_drive[1] = 1'b1;
        repeat (4) @(posedge clk);
        bus(1'b0, 1'b1, GPIO_FALL_EN, 32'h02, 1, rd, pulses);
        bus(1'b0, 1'b0, GPIO_STATUS, 32'h0, 1, rd, pulses);
        check("pre_fall_status", rd, 32'h0);
        @(negedge clk); pad_drive[1] = 1'b0;
        @(posedge clk);
        @(negedge clk);
        @(posedge clk);
        @(negedge clk); rw = 1'b1; addr = GPIO_STATUS; wdata = 32'h02; req_a = 1'b1;
        @(posedge clk);
        @(negedge clk); req_a = 1'b0;
        bus(1'b0, 1'b0, GPIO_STATUS, 32'h0, 1, rd, pulses);
        check("collision_status", rd, 32'h02);

        bus(1'b0, 1'b1, GPIO_FALL_EN, 32'h0, 1, rd, pulses);
        bus(1'b0, 1'b0, GPIO_STATUS, 32'h0, 1, rd, pulses);
        check("status_kept_after_en_clear", rd, 32'h02);
        check("irq_pending", 32'(irq_a), 32'h1);
        bus(1'b0, 1'b1, GPIO_STATUS, 32'h02, 1, rd, pulses);
        bus(1'b0, 1'b0, GPIO_STATUS, 32'h0, 1, rd, pulses);
        check("status_after_w1c", rd, 32'h0);
        check("irq_after_w1c", 32'(irq_a), 32'h0);

        // Narrow instance: upper write bits dropped, upper read bits zero.
        bus(1'b1, 1'b1, GPIO_OUT, 32'hFFFF_FFFF, 1, rd, pulses);
        bus(1'b1, 1'b0, GPIO_OUT, 32'h0, 1, rd, pulses);
        check("narrow_out", rd, 32'h0000_000F);
        check("narrow_pins", 32'(gout_b), 32'hF);
        bus(1'b1, 1'b1, GPIO_DIR, 32'hFFFF_FFF6, 1, rd, pulses);
        bus(1'b1, 1'b0, GPIO_DIR, 32'h0, 1, rd, pulses);
        check("narrow_dir", rd, 32'h0000_0006);

        // Asynchronous reset in the middle of an ACK cycle.
        @(negedge clk); rw = 1'b1; addr = GPIO_DIR; wdata = 32'h9; req_b = 1'b1;
        @(posedge clk); #1;
        check("ack_before_reset", 32'(ready_b), 32'h1);
        #2 rst = 1'b1;
        #1;
        check("ready_on_reset", 32'(ready_b), 32'h0);
        check("rdata_on_reset", rdata_b, 32'h0);
        check("narrow_out_on_reset", 32'(gout_b), 32'h0);
        check("narrow_oe_on_reset", 32'(goe_b), 32'h0);
        check("wide_out_on_reset", 32'(gout_a), 32'hA5);
        check("wide_oe_on_reset", 32'(goe_a), 32'h0F);
        check("wide_irq_on_reset", 32'(irq_a), 32'h0);
        @(negedge clk); req_b = 1'b0; rst = 1'b0;
        pulses = 0;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            if (ready_b) pulses++;
        end
        check("no_ready_after_reset", 32'(pulses), 32'd0);
        bus(1'b1, 1'b0, GPIO_DIR, 32'h0, 1, rd, pulses);
        check("narrow_dir_after_reset", rd, 32'h0);
        bus(1'b1, 1'b0, GPIO_OUT, 32'h0, 1, rd, pulses);
        check("narrow_out_after_reset", rd, 32'h0);
        bus(1'b0, 1'b0, GPIO_RISE_EN, 32'h0, 1, rd, pulses);
        check("wide_rise_en_after_reset", rd, 32'h0);
        bus(1'b0, 1'b0, GPIO_STATUS, 32'h0, 1, rd, pulses);
        check("wide_status_after_reset", rd, 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
